// File: rtl/hsid_sq_df_pkg.sv
// -----------------------------------------------------------------------------
// hsid_sq_df_pkg
// Shared types and constants for the squared-difference accumulator.
//   state_t        : controller states (IDLE, FEED, DRAIN, DONE)
//   PIPE_DEPTH     : number of register stages from beat handshake to result
//   lane_sum_width : width needed to hold the sum of LANES squared differences
// -----------------------------------------------------------------------------
package hsid_sq_df_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int PIPE_DEPTH = 4;

    // A square of a DW-bit value needs 2*DW bits; summing LANES of them
    // adds clog2(LANES) carry bits.
    function automatic int lane_sum_width(input int dw, input int lanes);
        return 2 * dw + $clog2(lanes);
    endfunction

endpackage

// File: rtl/hsid_sq_df_lane.sv
// -----------------------------------------------------------------------------
// hsid_sq_df_lane
// One band lane of the squared-difference pipeline: stage 1 registers the
// unsigned absolute difference, stage 2 registers its square.
// Ports:
//   i_clk, i_rst  : clock and synchronous active-high reset
//   i_valid       : a beat is entering stage 1 this cycle
//   i_v1, i_v2    : the two band samples (unsigned)
//   o_sq          : (v1-v2)^2, 2*DATA_WIDTH bits, two cycles after i_valid
//   o_valid       : qualifies o_sq
// -----------------------------------------------------------------------------
module hsid_sq_df_lane
    import hsid_sq_df_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_valid,
    input  logic [DATA_WIDTH-1:0]   i_v1,
    input  logic [DATA_WIDTH-1:0]   i_v2,
    output logic [2*DATA_WIDTH-1:0] o_sq,
    output logic                    o_valid
);

    logic [DATA_WIDTH-1:0]   r_absDiff;
    logic                    r_s1Valid;
    logic [2*DATA_WIDTH-1:0] r_sq;
    logic                    r_s2Valid;
    logic [DATA_WIDTH-1:0]   w_absDiff;
    logic [2*DATA_WIDTH-1:0] w_absExt;

    // Subtract the smaller from the larger so the difference never wraps.
    assign w_absDiff = (i_v1 >= i_v2) ? (i_v1 - i_v2) : (i_v2 - i_v1);
    assign w_absExt  = (2*DATA_WIDTH)'(r_absDiff);

    // Stage 1 and stage 2 registers travel together with their valid bits.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_absDiff <= '0;
            r_s1Valid <= 1'b0;
            r_sq      <= '0;
            r_s2Valid <= 1'b0;
        end else begin
            r_absDiff <= w_absDiff;
            r_s1Valid <= i_valid;
            r_sq      <= w_absExt * w_absExt;
            r_s2Valid <= r_s1Valid;
        end
    end

    assign o_sq    = r_sq;
    assign o_valid = r_s2Valid;

endmodule

// File: rtl/hsid_sq_df_acc.sv
// -----------------------------------------------------------------------------
// hsid_sq_df_acc
// Multi-lane squared-difference accumulator: returns the squared Euclidean
// distance between two spectral vectors streamed LANES bands per beat.
// Optional feature macro: HSID_SQ_DF_SAT_EN
//   defined     -> accumulator saturates at all-ones, o_out_overflow sticky
//   not defined -> accumulator wraps, o_out_overflow tied low
// Ports:
//   i_clk, i_rst       : clock and synchronous active-high reset
//   i_start            : begin a vector (only honoured in IDLE)
//   i_num_beats        : beats in the vector, captured with i_start
//   o_busy             : controller not in IDLE
//   i_in_valid         : input beat valid
//   o_in_ready         : high while beats are being accepted
//   i_in_v1, i_in_v2   : packed band samples, lane i at [i*DW +: DW]
//   i_in_lane_mask     : per-lane enable for the beat
//   o_out_valid        : result valid, held until i_out_ready
//   i_out_ready        : result consumer ready
//   o_out_acc          : accumulated squared distance
//   o_out_overflow     : accumulation exceeded ACC_WIDTH (saturating build)
// -----------------------------------------------------------------------------
module hsid_sq_df_acc
    import hsid_sq_df_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int LANES       = 4,
    parameter int COUNT_WIDTH = 8,
    parameter int ACC_WIDTH   = 48
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_start,
    input  logic [COUNT_WIDTH-1:0]        i_num_beats,
    output logic                          o_busy,
    input  logic                          i_in_valid,
    output logic                          o_in_ready,
    input  logic [LANES*DATA_WIDTH-1:0]   i_in_v1,
    input  logic [LANES*DATA_WIDTH-1:0]   i_in_v2,
    input  logic [LANES-1:0]              i_in_lane_mask,
    output logic                          o_out_valid,
    input  logic                          i_out_ready,
    output logic [ACC_WIDTH-1:0]          o_out_acc,
    output logic                          o_out_overflow
);

    localparam int SQW = 2 * DATA_WIDTH;
    localparam int LSW = lane_sum_width(DATA_WIDTH, LANES);
    localparam int DCW = $clog2(PIPE_DEPTH);

    // The accumulator must at least hold one beat's worth of lane sum.
    generate
        if (ACC_WIDTH < LSW) begin : g_badAccWidth
            $error("hsid_sq_df_acc: ACC_WIDTH must be >= 2*DATA_WIDTH+clog2(LANES)");
        end
    endgenerate

    state_t                 r_state;
    state_t                 w_nextState;
    logic [COUNT_WIDTH-1:0] r_numBeats;
    logic [COUNT_WIDTH-1:0] r_beatCnt;
    logic [DCW-1:0]         r_drainCnt;
    logic [LANES-1:0]       r_maskS1;
    logic [LANES-1:0]       r_maskS2;
    logic [LSW-1:0]         r_s3Sum;
    logic                   r_s3Valid;
    logic [ACC_WIDTH-1:0]   r_acc;

    logic                   w_startFire;
    logic                   w_beatFire;
    logic                   w_lastBeat;
    logic [SQW-1:0]         w_laneSq [LANES];
    logic [LANES-1:0]       w_laneValid;
    logic                   w_s2Valid;
    logic [LSW-1:0]         w_laneSum;

    assign w_startFire = (r_state == IDLE) && i_start;
    assign w_beatFire  = (r_state == FEED) && i_in_valid;
    assign w_lastBeat  = w_beatFire && (r_beatCnt == (r_numBeats - COUNT_WIDTH'(1)));

    // Per-lane abs-diff and square stages; every lane sees the same valid.
    generate
        for (genvar g = 0; g < LANES; g++) begin : g_lane
            hsid_sq_df_lane #(
                .DATA_WIDTH (DATA_WIDTH)
            ) u_lane (
                .i_clk   (i_clk),
                .i_rst   (i_rst),
                .i_valid (w_beatFire),
                .i_v1    (i_in_v1[g*DATA_WIDTH +: DATA_WIDTH]),
                .i_v2    (i_in_v2[g*DATA_WIDTH +: DATA_WIDTH]),
                .o_sq    (w_laneSq[g]),
                .o_valid (w_laneValid[g])
            );
        end
    endgenerate

    assign w_s2Valid = &w_laneValid;

    // Next-state logic. A zero-length vector goes straight to DONE with a
    // cleared accumulator; DRAIN waits until the last beat has left the pipe.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_nextState = (i_num_beats == '0) ? DONE : FEED;
                end
            end
            FEED: begin
                if (w_lastBeat) begin
                    w_nextState = DRAIN;
                end
            end
            DRAIN: begin
                if (r_drainCnt == DCW'(PIPE_DEPTH - 1)) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                if (i_out_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // State register plus the beat and drain counters that steer it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_numBeats <= '0;
            r_beatCnt  <= '0;
            r_drainCnt <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_startFire) begin
                r_numBeats <= i_num_beats;
                r_beatCnt  <= '0;
            end else if (w_beatFire) begin
                r_beatCnt <= r_beatCnt + COUNT_WIDTH'(1);
            end
            if (r_state == DRAIN) begin
                r_drainCnt <= r_drainCnt + DCW'(1);
            end else begin
                r_drainCnt <= '0;
            end
        end
    end

    // The lane mask is delayed to line up with the squares leaving stage 2.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_maskS1 <= '0;
            r_maskS2 <= '0;
        end else begin
            r_maskS1 <= i_in_lane_mask;
            r_maskS2 <= r_maskS1;
        end
    end

    // Adder tree over the enabled lanes.
    always_comb begin
        w_laneSum = '0;
        for (int i = 0; i < LANES; i++) begin
            if (r_maskS2[i]) begin
                w_laneSum = w_laneSum + LSW'(w_laneSq[i]);
            end
        end
    end

    // Stage 3 register: masked lane sum for one beat.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s3Sum   <= '0;
            r_s3Valid <= 1'b0;
        end else begin
            r_s3Sum   <= w_laneSum;
            r_s3Valid <= w_s2Valid;
        end
    end

`ifdef HSID_SQ_DF_SAT_EN
    logic               r_overflow;
    logic [ACC_WIDTH:0] w_accSum;

    // One spare bit catches the carry out so the sum can clamp.
    assign w_accSum = {1'b0, r_acc} + (ACC_WIDTH + 1)'(r_s3Sum);

    // Stage 4: saturating accumulator, overflow sticky until the next start.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc      <= '0;
            r_overflow <= 1'b0;
        end else if (w_startFire) begin
            r_acc      <= '0;
            r_overflow <= 1'b0;
        end else if (r_s3Valid) begin
            if (w_accSum[ACC_WIDTH]) begin
                r_acc      <= '1;
                r_overflow <= 1'b1;
            end else begin
                r_acc <= w_accSum[ACC_WIDTH-1:0];
            end
        end
    end

    assign o_out_overflow = r_overflow;
`else
    logic [ACC_WIDTH-1:0] w_accSum;

    assign w_accSum = r_acc + ACC_WIDTH'(r_s3Sum);

    // Stage 4: wrapping accumulator, cleared when a vector starts.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc <= '0;
        end else if (w_startFire) begin
            r_acc <= '0;
        end else if (r_s3Valid) begin
            r_acc <= w_accSum;
        end
    end

    assign o_out_overflow = 1'b0;
`endif

    // The accumulator only changes while beats are in flight, so it doubles
    // as the held result register during DONE and afterwards.
    assign o_busy      = (r_state != IDLE);
    assign o_in_ready  = (r_state == FEED);
    assign o_out_valid = (r_state == DONE);
    assign o_out_acc   = r_acc;

endmodule

// File: tb/tb_hsid_sq_df_acc.sv
// -----------------------------------------------------------------------------
// tb_hsid_sq_df_acc
// Directed self-checking bench for hsid_sq_df_acc. Instance A uses the
// default 48-bit accumulator; instance B uses a 34-bit accumulator to reach
// the wrap/saturate boundary. Both share the beat inputs; each has its own
// start, and an idle instance ignores beats.
// -----------------------------------------------------------------------------
module tb_hsid_sq_df_acc;

    logic        clk = 1'b0;
    logic        rst;
    logic        startA;
    logic        startB;
    logic [7:0]  numBeats;
    logic        inValid;
    logic [63:0] v1;
    logic [63:0] v2;
    logic [3:0]  mask;
    logic        outReady;

    logic        busyA, inReadyA, outValidA, ovfA;
    logic [47:0] outAccA;
    logic        busyB, inReadyB, outValidB, ovfB;
    logic [33:0] outAccB;

    logic        useB;
    int          checks;
    int          errors;

    always #5 clk = ~clk;

    hsid_sq_df_acc #(
        .DATA_WIDTH  (16),
        .LANES       (4),
        .COUNT_WIDTH (8),
        .ACC_WIDTH   (48)
    ) dutA (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start        (startA),
        .i_num_beats    (numBeats),
        .o_busy         (busyA),
        .i_in_valid     (inValid),
        .o_in_ready     (inReadyA),
        .i_in_v1        (v1),
        .i_in_v2        (v2),
        .i_in_lane_mask (mask),
        .o_out_valid    (outValidA),
        .i_out_ready    (outReady),
        .o_out_acc      (outAccA),
        .o_out_overflow (ovfA)
    );

    hsid_sq_df_acc #(
        .DATA_WIDTH  (16),
        .LANES       (4),
        .COUNT_WIDTH (8),
        .ACC_WIDTH   (34)
    ) dutB (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start        (startB),
        .i_num_beats    (numBeats),
        .o_busy         (busyB),
        .i_in_valid     (inValid),
        .o_in_ready     (inReadyB),
        .i_in_v1        (v1),
        .i_in_v2        (v2),
        .i_in_lane_mask (mask),
        .o_out_valid    (outValidB),
        .i_out_ready    (outReady),
        .o_out_acc      (outAccB),
        .o_out_overflow (ovfB)
    );

    // Pulse start for one edge; called and returns on a falling edge.
    task automatic startVector(input logic [7:0] n, input logic selB);
        numBeats = n;
        if (selB) startB = 1'b1;
        else      startA = 1'b1;
        @(posedge clk);
        @(negedge clk);
        startA = 1'b0;
        startB = 1'b0;
    endtask

    // Present one beat and hold it until the selected instance takes it.
    task automatic sendBeat(input logic [63:0] a, input logic [63:0] b, input logic [3:0] m);
        int waitCycles;
        waitCycles = 0;
        while (((useB ? inReadyB : inReadyA) !== 1'b1) && (waitCycles < 20)) begin
            @(negedge clk);
            waitCycles++;
        end
        if (waitCycles >= 20) begin
            checks++;
            errors++;
            $display("[TB] FAIL beat_accept: in_ready never rose (waited %0d cycles)", waitCycles);
        end else begin
            v1      = a;
            v2      = b;
            mask    = m;
            inValid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            inValid = 1'b0;
        end
    endtask

    // Count edges from the current falling edge until out_valid is seen.
    task automatic waitValid(input logic selB, output int cycles);
        cycles = 0;
        while (((selB ? outValidB : outValidA) !== 1'b1) && (cycles < 20)) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic finishResult();
        outReady = 1'b1;
        @(negedge clk);
        outReady = 1'b0;
    endtask

    task automatic test_reset();
        bit sawValid;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busyA, inReadyA, outValidA, ovfA} !== 4'b0000 || outAccA !== 48'd0) begin
            errors++;
            $display("[TB] FAIL reset_state: busy/rdy/vld/ovf=%b acc=%0d, required 0000 acc=0",
                     {busyA, inReadyA, outValidA, ovfA}, outAccA);
        end
        startVector(8'd3, 1'b0);
        sendBeat({4{16'd100}}, 64'd0, 4'hf);
        checks++;
        if (busyA !== 1'b1 || inReadyA !== 1'b1) begin
            errors++;
            $display("[TB] FAIL feed_before_reset: busy=%b in_ready=%b, required 1 1", busyA, inReadyA);
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busyA, inReadyA, outValidA} !== 3'b000 || outAccA !== 48'd0) begin
            errors++;
            $display("[TB] FAIL mid_feed_reset: busy/rdy/vld=%b acc=%0d, required 000 acc=0",
                     {busyA, inReadyA, outValidA}, outAccA);
        end
        rst = 1'b0;
        sawValid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (outValidA === 1'b1 || busyA === 1'b1) sawValid = 1'b1;
        end
        checks++;
        if (sawValid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL no_result_after_reset: activity seen=%b, required 0", sawValid);
        end
    endtask

    task automatic test_two_beats();
        int lat;
        startVector(8'd2, 1'b0);
        sendBeat({16'd40, 16'd30, 16'd20, 16'd10}, {16'd0, 16'd30, 16'd25, 16'd7}, 4'hf);
        sendBeat({4{16'd1}}, 64'd0, 4'hf);
        waitValid(1'b0, lat);
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("[TB] FAIL two_beat_latency: %0d cycles, required 4", lat);
        end
        checks++;
        if (outAccA !== 48'd1638) begin
            errors++;
            $display("[TB] FAIL two_beat_acc: got %0d, required 1638", outAccA);
        end
        checks++;
        if (ovfA !== 1'b0 || inReadyA !== 1'b0) begin
            errors++;
            $display("[TB] FAIL two_beat_flags: ovf=%b in_ready=%b, required 0 0", ovfA, inReadyA);
        end
        finishResult();
        checks++;
        if (outValidA !== 1'b0 || busyA !== 1'b0 || outAccA !== 48'd1638) begin
            errors++;
            $display("[TB] FAIL two_beat_release: vld=%b busy=%b acc=%0d, required 0 0 1638",
                     outValidA, busyA, outAccA);
        end
    endtask

    task automatic test_unsigned_edge();
        int lat;
        startVector(8'd1, 1'b0);
        sendBeat({16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000}, {16'h0, 16'h0, 16'h0, 16'hFFFF}, 4'b0001);
        waitValid(1'b0, lat);
        checks++;
        if (lat !== 4 || outAccA !== 48'd4294836225) begin
            errors++;
            $display("[TB] FAIL unsigned_edge: lat=%0d acc=%0d, required 4 4294836225", lat, outAccA);
        end
        finishResult();
    endtask

    task automatic test_back_pressure();
        int lat;
        startVector(8'd1, 1'b0);
        sendBeat({48'd0, 16'd5}, {48'd0, 16'd2}, 4'b0001);
        waitValid(1'b0, lat);
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("[TB] FAIL bp_latency: %0d cycles, required 4", lat);
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (outValidA !== 1'b1 || outAccA !== 48'd9 || inReadyA !== 1'b0) begin
                errors++;
                $display("[TB] FAIL bp_hold[%0d]: vld=%b acc=%0d rdy=%b, required 1 9 0",
                         i, outValidA, outAccA, inReadyA);
            end
            numBeats = 8'd1;
            startA   = (i == 4);
            @(negedge clk);
        end
        startA   = 1'b1;
        outReady = 1'b1;
        @(negedge clk);
        startA   = 1'b0;
        outReady = 1'b0;
        checks++;
        if (busyA !== 1'b0 || outValidA !== 1'b0 || outAccA !== 48'd9) begin
            errors++;
            $display("[TB] FAIL bp_release: busy=%b vld=%b acc=%0d, required 0 0 9",
                     busyA, outValidA, outAccA);
        end
    endtask

    task automatic test_zero_beats();
        startVector(8'd0, 1'b0);
        checks++;
        if (outValidA !== 1'b1 || outAccA !== 48'd0 || inReadyA !== 1'b0) begin
            errors++;
            $display("[TB] FAIL zero_beats: vld=%b acc=%0d rdy=%b, required 1 0 0",
                     outValidA, outAccA, inReadyA);
        end
        finishResult();
        checks++;
        if (busyA !== 1'b0 || outValidA !== 1'b0) begin
            errors++;
            $display("[TB] FAIL zero_beats_release: busy=%b vld=%b, required 0 0", busyA, outValidA);
        end
    endtask

    task automatic test_acc_boundary();
        int          lat;
        logic [33:0] expAcc;
        logic        expOvf;
`ifdef HSID_SQ_DF_SAT_EN
        expAcc = 34'd17179869183;
        expOvf = 1'b1;
`else
        expAcc = 34'd17178820616;
        expOvf = 1'b0;
`endif
        useB = 1'b1;
        startVector(8'd2, 1'b1);
        sendBeat({4{16'hFFFF}}, 64'd0, 4'hf);
        sendBeat({4{16'hFFFF}}, 64'd0, 4'hf);
        waitValid(1'b1, lat);
        checks++;
        if (lat !== 4 || outAccB !== expAcc) begin
            errors++;
            $display("[TB] FAIL acc34_value: lat=%0d acc=%0d, required 4 %0d", lat, outAccB, expAcc);
        end
        checks++;
        if (ovfB !== expOvf) begin
            errors++;
            $display("[TB] FAIL acc34_overflow: got %b, required %b", ovfB, expOvf);
        end
        checks++;
        if (busyA !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_instance: busyA=%b, required 0", busyA);
        end
        finishResult();
        startVector(8'd0, 1'b1);
        checks++;
        if (outValidB !== 1'b1 || outAccB !== 34'd0 || ovfB !== 1'b0) begin
            errors++;
            $display("[TB] FAIL acc34_restart: vld=%b acc=%0d ovf=%b, required 1 0 0",
                     outValidB, outAccB, ovfB);
        end
        finishResult();
        useB = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        startA   = 1'b0;
        startB   = 1'b0;
        numBeats = 8'd0;
        inValid  = 1'b0;
        v1       = 64'd0;
        v2       = 64'd0;
        mask     = 4'h0;
        outReady = 1'b0;
        useB     = 1'b0;
        @(negedge clk);
        test_reset();
        test_two_beats();
        test_unsigned_edge();
        test_back_pressure();
        test_zero_beats();
        test_acc_boundary();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
